// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: operand forwarding mux, load-use stall detection and
// the ID/EX pipeline register with flush/hold/bubble handling.
module id_ex_operand_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       rf_a,
  input  logic [31:0]       rf_b,
  input  logic [31:0]       rf_c,
  input  logic [3:0]        sel_a,
  input  logic [3:0]        sel_b,
  input  logic [3:0]        sel_c,
  input  logic              use_a,
  input  logic              use_b,
  input  logic              use_c,
  input  logic              ex_wr_en,
  input  logic [3:0]        ex_wr_reg,
  input  logic [31:0]       ex_wr_data,
  input  logic              ex_is_load,
  input  logic              mem_wr_en,
  input  logic [3:0]        mem_wr_reg,
  input  logic [31:0]       mem_wr_data,
  input  logic              wb_wr_en,
  input  logic [3:0]        wb_wr_reg,
  input  logic [31:0]       wb_wr_data,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [31:0]       pc4_in,
  input  logic              flush,
  input  logic              hold,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic [31:0]       op_c,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [31:0]       pc4_out,
  output logic              ex_valid,
  output logic              stall_out,
  output logic [15:0]       bubble_count
);

  localparam logic [3:0] R15 = 4'hF;

  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [31:0]       op_c_q, op_c_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [15:0]       bubble_q, bubble_d;

  logic [31:0] fwd_a, fwd_b, fwd_c;
  logic        load_use;

  // EX result of a load is not available yet, so it is never forwarded;
  // R15 always reads straight from the register file.
  function automatic logic [31:0] forward(
    input logic [3:0]  sel,
    input logic [31:0] rf,
    input logic        ex_en,
    input logic [3:0]  ex_reg,
    input logic [31:0] ex_data,
    input logic        ex_load,
    input logic        mem_en,
    input logic [3:0]  mem_reg,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [3:0]  wb_reg,
    input logic [31:0] wb_data
  );
    logic [31:0] v;
    v = rf;
    if (sel != R15) begin
      if (ex_en && (ex_reg == sel) && !ex_load)  v = ex_data;
      else if (mem_en && (mem_reg == sel))       v = mem_data;
      else if (wb_en && (wb_reg == sel))         v = wb_data;
    end
    return v;
  endfunction

  // Forwarded operands and load-use hazard detection
  always_comb begin
    fwd_a = forward(sel_a, rf_a, ex_wr_en, ex_wr_reg, ex_wr_data, ex_is_load,
                    mem_wr_en, mem_wr_reg, mem_wr_data, wb_wr_en, wb_wr_reg, wb_wr_data);
    fwd_b = forward(sel_b, rf_b, ex_wr_en, ex_wr_reg, ex_wr_data, ex_is_load,
                    mem_wr_en, mem_wr_reg, mem_wr_data, wb_wr_en, wb_wr_reg, wb_wr_data);
    fwd_c = forward(sel_c, rf_c, ex_wr_en, ex_wr_reg, ex_wr_data, ex_is_load,
                    mem_wr_en, mem_wr_reg, mem_wr_data, wb_wr_en, wb_wr_reg, wb_wr_data);
    load_use = id_valid && ex_wr_en && ex_is_load &&
               ((use_a && (ex_wr_reg == sel_a) && (sel_a != R15)) ||
                (use_b && (ex_wr_reg == sel_b) && (sel_b != R15)) ||
                (use_c && (ex_wr_reg == sel_c) && (sel_c != R15)));
    stall_out = hold || load_use;
  end

  // Next-state for the ID/EX register: flush > hold > load-use bubble > capture
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_c_d   = op_c_q;
    ctrl_d   = ctrl_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold) begin
      // everything frozen
    end else if (load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    end else begin
      op_a_d  = fwd_a;
      op_b_d  = fwd_b;
      op_c_d  = fwd_c;
      ctrl_d  = id_valid ? ctrl_in : '0;
      pc4_d   = pc4_in;
      valid_d = id_valid;
    end
  end

  // ID/EX pipeline register with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= '0;
      ctrl_q   <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_c_q   <= op_c_d;
      ctrl_q   <= ctrl_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_c         = op_c_q;
  assign ctrl_out     = ctrl_q;
  assign pc4_out      = pc4_q;
  assign ex_valid     = valid_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rf_a, rf_b, rf_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic        use_a, use_b, use_c;
  logic        ex_wr_en, ex_is_load;
  logic [3:0]  ex_wr_reg;
  logic [31:0] ex_wr_data;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_reg;
  logic [31:0] mem_wr_data;
  logic        wb_wr_en;
  logic [3:0]  wb_wr_reg;
  logic [31:0] wb_wr_data;
  logic        id_valid;
  logic [15:0] ctrl_in;
  logic [31:0] pc4_in;
  logic        flush, hold;
  logic [31:0] op_a, op_b, op_c;
  logic [15:0] ctrl_out;
  logic [31:0] pc4_out;
  logic        ex_valid, stall_out;
  logic [15:0] bubble_count;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage #(.CTRL_W(16)) dut (
    .clock(clock), .reset(reset),
    .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
    .use_a(use_a), .use_b(use_b), .use_c(use_c),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
    .id_valid(id_valid), .ctrl_in(ctrl_in), .pc4_in(pc4_in),
    .flush(flush), .hold(hold),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .ctrl_out(ctrl_out), .pc4_out(pc4_out), .ex_valid(ex_valid),
    .stall_out(stall_out), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rf_a = '0; rf_b = '0; rf_c = '0;
    sel_a = '0; sel_b = '0; sel_c = '0;
    use_a = 0; use_b = 0; use_c = 0;
    ex_wr_en = 0; ex_wr_reg = '0; ex_wr_data = '0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_reg = '0; mem_wr_data = '0;
    wb_wr_en = 0; wb_wr_reg = '0; wb_wr_data = '0;
    id_valid = 0; ctrl_in = '0; pc4_in = '0;
    flush = 0; hold = 1;
    #1;
    check("rst_op_a", op_a, 0);
    check("rst_ex_valid", {31'd0, ex_valid}, 0);
    check("rst_bubble", {16'd0, bubble_count}, 0);
    check("rst_stall_follows_hold", {31'd0, stall_out}, 1);
    tick();
    check("rst_ctrl_no_change", {16'd0, ctrl_out}, 0);
    hold = 0;
    #1;
    check("rst_stall_low", {31'd0, stall_out}, 0);
    @(negedge clock);
    reset = 0;

    // basic capture
    sel_a = 4'd3; rf_a = 32'h1111_1111; use_a = 1; id_valid = 1; ctrl_in = 16'h00A5; pc4_in = 32'h104;
    tick();
    check("cap_op_a", op_a, 32'h1111_1111);
    check("cap_ctrl", {16'd0, ctrl_out}, 32'h00A5);
    check("cap_valid", {31'd0, ex_valid}, 1);
    check("cap_pc4", pc4_out, 32'h104);

    // forwarding priority on R5
    sel_b = 4'd5; use_b = 1; rf_b = 32'h0;
    ex_wr_en = 1; ex_wr_reg = 4'd5; ex_wr_data = 32'hE;
    mem_wr_en = 1; mem_wr_reg = 4'd5; mem_wr_data = 32'hD;
    wb_wr_en = 1; wb_wr_reg = 4'd5; wb_wr_data = 32'hB;
    tick();
    check("fwd_ex", op_b, 32'hE);
    check("fwd_ex_op_a_rf", op_a, 32'h1111_1111);
    ex_wr_en = 0;
    tick();
    check("fwd_mem", op_b, 32'hD);
    mem_wr_en = 0;
    tick();
    check("fwd_wb", op_b, 32'hB);
    wb_wr_en = 0; rf_b = 32'h22;
    tick();
    check("fwd_none", op_b, 32'h22);

    // R15 is never forwarded and never stalls
    sel_a = 4'hF; rf_a = 32'h40; use_a = 1;
    ex_wr_en = 1; ex_wr_reg = 4'hF; ex_wr_data = 32'hDEAD; ex_is_load = 1;
    #1;
    check("r15_no_stall", {31'd0, stall_out}, 0);
    tick();
    check("r15_op_a", op_a, 32'h40);
    check("r15_valid", {31'd0, ex_valid}, 1);

    // load-use hazard on operand c
    sel_a = 4'd3; rf_a = 32'h1111_1111;
    ex_wr_reg = 4'd7; sel_c = 4'd7; use_c = 1; rf_c = 32'h33;
    #1;
    check("lu_stall", {31'd0, stall_out}, 1);
    tick();
    check("lu_valid", {31'd0, ex_valid}, 0);
    check("lu_ctrl", {16'd0, ctrl_out}, 0);
    check("lu_bubble", {16'd0, bubble_count}, 1);
    check("lu_op_a_held", op_a, 32'h40);
    use_c = 0;
    #1;
    check("lu_unused_no_stall", {31'd0, stall_out}, 0);
    tick();
    check("lu_unused_op_c", op_c, 32'h33);
    check("lu_unused_valid", {31'd0, ex_valid}, 1);
    check("lu_unused_bubble", {16'd0, bubble_count}, 1);

    // flush wins over hold and hazard
    use_c = 1; hold = 1; flush = 1; ctrl_in = 16'h5A5A; rf_a = 32'h9999_9999;
    tick();
    check("fl_valid", {31'd0, ex_valid}, 0);
    check("fl_ctrl", {16'd0, ctrl_out}, 0);
    check("fl_bubble", {16'd0, bubble_count}, 1);
    check("fl_op_a_kept", op_a, 32'h1111_1111);

    // capture, then hold freezes everything
    flush = 0; hold = 0; use_c = 0; pc4_in = 32'h200;
    tick();
    check("pre_hold_ctrl", {16'd0, ctrl_out}, 32'h5A5A);
    hold = 1; use_c = 1; ctrl_in = 16'h0077; pc4_in = 32'h300; rf_a = 32'h1234_5678;
    tick();
    check("hold_ctrl", {16'd0, ctrl_out}, 32'h5A5A);
    check("hold_pc4", pc4_out, 32'h200);
    check("hold_op_a", op_a, 32'h9999_9999);
    check("hold_valid", {31'd0, ex_valid}, 1);
    check("hold_bubble", {16'd0, bubble_count}, 1);

    // reset mid-hold discards state; first edge after is a capture
    reset = 1;
    #1;
    check("mid_rst_op_a", op_a, 0);
    check("mid_rst_pc4", pc4_out, 0);
    check("mid_rst_bubble", {16'd0, bubble_count}, 0);
    check("mid_rst_stall", {31'd0, stall_out}, 1);
    @(negedge clock);
    reset = 0; hold = 0; use_c = 0;
    tick();
    check("post_rst_ctrl", {16'd0, ctrl_out}, 32'h0077);
    check("post_rst_valid", {31'd0, ex_valid}, 1);

    // invalid ID instruction captures as empty and never stalls
    id_valid = 0; use_c = 1;
    #1;
    check("nv_no_stall", {31'd0, stall_out}, 0);
    tick();
    check("nv_ctrl", {16'd0, ctrl_out}, 0);
    check("nv_valid", {31'd0, ex_valid}, 0);

    // bubble counter saturation
    id_valid = 1;
    repeat (65535) @(posedge clock);
    #1;
    check("sat_reach", {16'd0, bubble_count}, 32'hFFFF);
    tick();
    check("sat_hold", {16'd0, bubble_count}, 32'hFFFF);
    #3;
    reset = 1;
    #1;
    check("final_rst_bubble", {16'd0, bubble_count}, 0);
    check("final_rst_op_c", op_c, 0);
    check("final_rst_ctrl", {16'd0, ctrl_out}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
